oam_dma_ctrl: RTL

- Controller for OAM DMA (register FF46). It arbitrates the single shared CPU memory bus between the CPU and a DMA engine.
- The engine copies DMA_LEN bytes from {FF46, 8'h00} into OAM at OAM_BASE.
- It sits between the CPU bus port and the top-level address decode/read mux. It owns the FF46 register and drives the muxed bus seen by cart/WRAM/HRAM/PPU.

---
 rtl/oam_dma_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: owns FF46 and arbitrates the CPU bus between the CPU and the OAM copy engine.
// Build option OAM_DMA_CPU_LOCKOUT_EN: CPU is locked out of non-HRAM space while DMA runs (otherwise cycle-stealing).
module oam_dma_ctrl #(
    parameter logic [15:0] OAM_BASE    = 16'hFE00,
    parameter int          DMA_LEN     = 160,
    parameter logic [15:0] REG_ADDR    = 16'hFF46,
    parameter int          START_DELAY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_w,
    input  logic        cpu_do_write,
    output logic [7:0]  cpu_data_r,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_data_w,
    output logic        bus_do_write,
    input  logic [7:0]  bus_data_r,
    output logic        dma_active
);

    typedef enum logic [1:0] {IDLE, START, READ, WRITE} state_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        we;
    } bus_req_t;

    localparam logic [7:0] LAST = 8'(DMA_LEN - 1);
    localparam logic [1:0] DLY  = 2'(START_DELAY);

    state_t     state, state_nx;
    logic [7:0] dma_reg, dma_reg_nx;
    logic [7:0] count, count_nx;
    logic [7:0] latch, latch_nx;
    logic [1:0] dly, dly_nx;

    logic       reg_hit, reg_wr, hi_hit, cpu_prio, xfer;
    logic       dma_go, cpu_blocked;
    logic [7:0] src_hi;
    bus_req_t   cpu_req, dma_req, bus_req;

    assign reg_hit    = (cpu_addr == REG_ADDR);
    assign reg_wr     = reg_hit && cpu_do_write;
    assign hi_hit     = (cpu_addr[15:7] == 9'h1FF);   // FF80-FFFF: HRAM and IE
    assign cpu_prio   = reg_hit || hi_hit;
    assign xfer       = (state == READ) || (state == WRITE);
    assign dma_active = (state != IDLE);

`ifdef OAM_DMA_CPU_LOCKOUT_EN
    assign dma_go      = xfer && !cpu_prio;
    assign cpu_blocked = dma_active && !cpu_prio;
`else
    // CPU keeps the bus except while it touches the unused FEA0-FEFF hole.
    logic cpu_idle;
    assign cpu_idle    = (cpu_addr >= 16'hFEA0) && (cpu_addr <= 16'hFEFF);
    assign dma_go      = xfer && cpu_idle;
    assign cpu_blocked = dma_go;
`endif

    // E000-FFFF sources alias back onto WRAM.
    assign src_hi = (dma_reg < 8'hE0) ? dma_reg : dma_reg - 8'h20;

    always_comb begin
        dma_req = '{addr: {src_hi, count}, data: 8'h00, we: 1'b0};
        if (state == WRITE)
            dma_req = '{addr: OAM_BASE + {8'h00, count}, data: latch, we: 1'b1};
    end

    assign cpu_req = '{addr: cpu_addr, data: cpu_data_w,
                       we: cpu_do_write && !reg_hit && !cpu_blocked};
    assign bus_req = dma_go ? dma_req : cpu_req;

    assign bus_addr     = bus_req.addr;
    assign bus_data_w   = bus_req.data;
    assign bus_do_write = bus_req.we;

    assign cpu_data_r = reg_hit     ? dma_reg :
                        cpu_blocked ? 8'hFF   : bus_data_r;

    always_comb begin
        state_nx   = state;
        dma_reg_nx = dma_reg;
        count_nx   = count;
        latch_nx   = latch;
        dly_nx     = dly;
        case (state)
            START: begin
                if (dly <= 2'd1) state_nx = READ;
                else             dly_nx   = dly - 2'd1;
            end
            READ: begin
                if (dma_go) begin
                    latch_nx = bus_data_r;
                    state_nx = WRITE;
                end
            end
            WRITE: begin
                if (dma_go) begin
                    if (count == LAST) begin
                        state_nx = IDLE;
                    end else begin
                        count_nx = count + 8'd1;
                        state_nx = READ;
                    end
                end
            end
            default: ;
        endcase
        // A register write (re)starts the transfer from byte 0 in any state.
        if (reg_wr) begin
            dma_reg_nx = cpu_data_w;
            count_nx   = 8'h00;
            dly_nx     = DLY;
            state_nx   = (START_DELAY == 0) ? READ : START;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            dma_reg <= 8'h00;
            count   <= 8'h00;
            latch   <= 8'h00;
            dly     <= 2'd0;
        end else begin
            state   <= state_nx;
            dma_reg <= dma_reg_nx;
            count   <= count_nx;
            latch   <= latch_nx;
            dly     <= dly_nx;
        end
    end

endmodule
